// File: rtl/rr_replay_unpacker_if.sv
// rr_replay_unpacker_if: storage beat input stream and unpacked unit output stream
interface rr_replay_unpacker_if #(
  parameter int AXI_WIDTH = 512,
  parameter int FULL_WIDTH = 40,
  parameter int OFFSET_WIDTH = 6
);
  logic in_valid, in_ready;
  logic [AXI_WIDTH-1:0] in_data;
  logic out_valid, out_ready;
  logic [FULL_WIDTH-1:0] out_data;
  logic [OFFSET_WIDTH-1:0] out_len;
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_len);
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_len);
endinterface

// File: rtl/rr_replay_unpacker.sv
// rr_replay_unpacker: splits a contiguous LSB-first bit log into variable-length bitmap-headed units.
// Define RR_UNPACKER_CHECK_EN to flag truncated final units and non-zero padding on err.
module rr_replay_unpacker #(
  parameter int AXI_WIDTH = 512,
  parameter int LOGB_CHANNEL_CNT = 4,
  parameter int LOGE_CHANNEL_CNT = 4,
  parameter int RR_CHANNEL_WIDTH_BITS = 8,
  parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
    {LOGB_CHANNEL_CNT{RR_CHANNEL_WIDTH_BITS'(8)}}
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [31:0] cfg_total_bits,
  rr_replay_unpacker_if.slave bus,
  output logic busy,
  output logic done,
  output logic err
);
  function automatic int width_sum();
    int s;
    s = 0;
    for (int i = 0; i < LOGB_CHANNEL_CNT; i++) s += int'(CHANNEL_WIDTHS[i]);
    return s;
  endfunction
  localparam int FULL_WIDTH = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT + width_sum();
  localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1);
  localparam int BUF_WIDTH = 2 * AXI_WIDTH;
  localparam int FILL_WIDTH = $clog2(BUF_WIDTH + 1);
  localparam logic [FILL_WIDTH-1:0] LOGB_F = FILL_WIDTH'(LOGB_CHANNEL_CNT);
  localparam logic [FILL_WIDTH-1:0] AXI_F = FILL_WIDTH'(AXI_WIDTH);
  if (FULL_WIDTH > AXI_WIDTH) begin : g_width_check
    $error("FULL_WIDTH exceeds AXI_WIDTH");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [BUF_WIDTH-1:0] buf_q, buf_d;
  logic [FILL_WIDTH-1:0] fill_q, fill_d, fill_after;
  logic [32:0] fetched_q, fetched_d;
  logic [31:0] consumed_q, consumed_d, total_q, total_d, remaining;
  logic out_valid_q, out_valid_d, err_q, err_d;
  logic [FULL_WIDTH-1:0] out_data_q, out_data_d;
  logic [OFFSET_WIDTH-1:0] out_len_q, out_len_d, len;
  logic run, hdr, trunc, extract, finish, in_ready, accept, chk_err;
  always_comb begin
    len = OFFSET_WIDTH'(LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT);
    for (int i = 0; i < LOGB_CHANNEL_CNT; i++)
      len = len + (buf_q[i] ? OFFSET_WIDTH'(CHANNEL_WIDTHS[i]) : '0);
  end
  assign run = state_q == RUN;
  assign remaining = total_q - consumed_q;
  // once everything is fetched a short buffer still exposes a (zero-padded) header
  assign hdr = fill_q >= LOGB_F || fetched_q >= {1'b0, total_q};
  assign trunc = remaining != 0 && hdr && remaining < 32'(len);
  assign extract = run && fill_q >= LOGB_F && fill_q >= FILL_WIDTH'(len) && remaining >= 32'(len) &&
                   (!out_valid_q || bus.out_ready);
  assign finish = run && !out_valid_q && (remaining == 0 || trunc);
  assign fill_after = fill_q - (extract ? FILL_WIDTH'(len) : '0);
  assign in_ready = run && !finish && fill_after <= AXI_F && fetched_q < {1'b0, total_q};
  assign accept = bus.in_valid && in_ready;
`ifdef RR_UNPACKER_CHECK_EN
  assign chk_err = trunc || (remaining == 0 && |buf_q);
`else
  assign chk_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    fetched_d = fetched_q;
    consumed_d = consumed_q;
    total_d = total_q;
    err_d = err_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d = out_data_q;
    out_len_d = out_len_q;
    if (extract) begin
      out_valid_d = 1'b1;
      out_data_d = buf_q[FULL_WIDTH-1:0] & ~({FULL_WIDTH{1'b1}} << len);
      out_len_d = len;
      buf_d = buf_q >> len;
      consumed_d = consumed_q + 32'(len);
    end
    if (accept) begin
      buf_d = buf_d | (BUF_WIDTH'(bus.in_data) << fill_after);
      fetched_d = fetched_q + 33'(AXI_WIDTH);
    end
    fill_d = fill_after + (accept ? AXI_F : '0);
    if (finish) begin
      state_d = DONE;
      buf_d = '0;
      fill_d = '0;
      err_d = err_q | chk_err;
    end
    if (start && !run) begin
      state_d = RUN;
      total_d = cfg_total_bits;
      fetched_d = '0;
      consumed_d = '0;
      fill_d = '0;
      buf_d = '0;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q <= '0;
      fill_q <= '0;
      fetched_q <= '0;
      consumed_q <= '0;
      total_q <= '0;
      err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_len_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      fill_q <= fill_d;
      fetched_q <= fetched_d;
      consumed_q <= consumed_d;
      total_q <= total_d;
      err_q <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_len_q <= out_len_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_len = out_len_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign err = err_q;
endmodule

// File: tb/tb_rr_replay_unpacker.sv
// tb_rr_replay_unpacker: directed scoreboard bench, 64-bit beats, widths {30,20}, LOGB=2, LOGE=1
module tb_rr_replay_unpacker;
  localparam int AW = 64, FW = 53, OW = 6;
`ifdef RR_UNPACKER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] cfg_total_bits = '0;
  logic busy, done, err;
  int checks = 0, passed = 0, acc = 0, emitted = 0;
  logic rdy_seen = 1'b0;
  int q_len[$];
  logic [FW-1:0] q_data[$];
  logic [255:0] stream;
  int spos;
  rr_replay_unpacker_if #(.AXI_WIDTH(AW), .FULL_WIDTH(FW), .OFFSET_WIDTH(OW)) bus ();
  rr_replay_unpacker #(
    .AXI_WIDTH(AW), .LOGB_CHANNEL_CNT(2), .LOGE_CHANNEL_CNT(1), .RR_CHANNEL_WIDTH_BITS(8),
    .CHANNEL_WIDTHS({8'd30, 8'd20})
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_total_bits(cfg_total_bits),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask
  always @(negedge clk) begin
    #3;
    if (bus.in_valid && bus.in_ready) acc++;
    if (bus.in_ready) rdy_seen = 1'b1;
    if (bus.out_valid && bus.out_ready) begin
      emitted++;
      chk("unit_expected", 64'(q_len.size() != 0), 64'd1);
      if (q_len.size() != 0) begin
        chk("out_len", 64'(bus.out_len), 64'(q_len[0]));
        chk("out_data", 64'(bus.out_data), 64'(q_data[0]));
        void'(q_len.pop_front());
        void'(q_data.pop_front());
      end
    end
  end
  task automatic clear_log();
    stream = '0;
    spos = 0;
    q_len.delete();
    q_data.delete();
  endtask
  task automatic add_unit(input logic [1:0] bm);
    int l;
    logic [63:0] r;
    logic [FW-1:0] u;
    l = 3 + (bm[0] ? 20 : 0) + (bm[1] ? 30 : 0);
    r = {$urandom(), $urandom()};
    u = r[FW-1:0];
    u[1:0] = bm;
    for (int i = l; i < FW; i++) u[i] = 1'b0;
    for (int i = 0; i < l; i++) stream[spos + i] = u[i];
    spos += l;
    q_len.push_back(l);
    q_data.push_back(u);
  endtask
  task automatic begin_pass(input int total);
    acc = 0;
    emitted = 0;
    rdy_seen = 1'b0;
    @(negedge clk);
    cfg_total_bits = total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic send_beats(input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      int t;
      t = 0;
      bus.in_valid = 1'b1;
      bus.in_data = stream[k*AW +: AW];
      #1;
      while (!bus.in_ready && t < 100) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk("beat_accept", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    #4;
    chk(tag, 64'(done), 64'd1);
    chk({tag, "_drained"}, 64'(q_len.size()), 64'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_len", 64'(bus.out_len), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    rst = 1'b0;
    // three units 23+53+3 over two beats; extra beat offered but must not be taken
    clear_log();
    add_unit(2'b01);
    add_unit(2'b11);
    add_unit(2'b00);
    begin_pass(spos);
    chk("t1_busy", 64'(busy), 64'd1);
    send_beats(0, 2);
    bus.in_valid = 1'b1;
    bus.in_data = '1;
    wait_done("t1_done");
    bus.in_valid = 1'b0;
    chk("t1_beats", 64'(acc), 64'd2);
    chk("t1_units", 64'(emitted), 64'd3);
    chk("t1_err", 64'(err), 64'd0);
    // backpressure with a pending unit
    clear_log();
    add_unit(2'b11);
    add_unit(2'b11);
    add_unit(2'b01);
    add_unit(2'b00);
    bus.out_ready = 1'b0;
    begin_pass(spos);
    send_beats(0, 2);
    for (int c = 0; c < 5; c++) begin
      #4;
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_out_len", 64'(bus.out_len), 64'(q_len[0]));
      chk("bp_out_data", 64'(bus.out_data), 64'(q_data[0]));
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send_beats(2, 1);
    wait_done("bp_done");
    chk("bp_beats", 64'(acc), 64'd3);
    chk("bp_units", 64'(emitted), 64'd4);
    // 53-bit unit straddling the beat boundary
    clear_log();
    add_unit(2'b01);
    add_unit(2'b01);
    add_unit(2'b11);
    begin_pass(spos);
    send_beats(0, 1);
    repeat (6) @(negedge clk);
    #4;
    chk("split_wait_valid", 64'(bus.out_valid), 64'd0);
    chk("split_wait_units", 64'(emitted), 64'd2);
    @(negedge clk);
    send_beats(1, 1);
    wait_done("split_done");
    chk("split_units", 64'(emitted), 64'd3);
    // empty log
    clear_log();
    begin_pass(0);
    @(negedge clk);
    #4;
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_in_ready", 64'(rdy_seen), 64'd0);
    chk("empty_units", 64'(emitted), 64'd0);
    // single 3-bit unit
    clear_log();
    add_unit(2'b00);
    begin_pass(spos);
    send_beats(0, 1);
    wait_done("short_done");
    chk("short_units", 64'(emitted), 64'd1);
    chk("short_beats", 64'(acc), 64'd1);
    // reset mid-run with units buffered, then a fresh pass
    clear_log();
    add_unit(2'b01);
    add_unit(2'b01);
    add_unit(2'b11);
    bus.out_ready = 1'b0;
    begin_pass(spos);
    send_beats(0, 2);
    @(negedge clk);
    rst = 1'b1;
    #4;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    clear_log();
    add_unit(2'b00);
    begin_pass(spos);
    send_beats(0, 1);
    wait_done("midrst_done2");
    chk("midrst_units", 64'(emitted), 64'd1);
    // total=40 holds 23 then a truncated 53
    clear_log();
    add_unit(2'b01);
    add_unit(2'b11);
    void'(q_len.pop_back());
    void'(q_data.pop_back());
    begin_pass(40);
    send_beats(0, 1);
    wait_done("trunc_done");
    chk("trunc_err", 64'(err), 64'(CHK));
    chk("trunc_units", 64'(emitted), 64'd1);
    // non-zero padding after the final unit
    clear_log();
    add_unit(2'b00);
    stream[10] = 1'b1;
    begin_pass(3);
    send_beats(0, 1);
    wait_done("pad_done");
    chk("pad_err", 64'(err), 64'(CHK));
    chk("pad_units", 64'(emitted), 64'd1);
    clear_log();
    begin_pass(0);
    #4;
    chk("restart_err_clear", 64'(err), 64'd0);
    wait_done("restart_done");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
